rx_deser: RTL and testbench
===========================

# rx_deser

Parametrised serial-to-parallel deserialiser for the receive path. It has configurable word width and bit order, an internal bit counter, frame framing (start and complete), and a holding register with ready, valid and overrun tracking. It sits between the receiver sampling/timer logic, which supplies `shift_enable` strobes, and the consumer of received words.

## Interface
- `DATA_BITS`, 8, payload width; legal range is 5..16.
- `MSB_FIRST`, 0, bit order: 0 = LSB received first, 1 = MSB received first.
- `PARITY_ODD`, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `frame_start`  in  1  single-cycle pulse; begins (or restarts) a frame.
- `shift_enable`  in  1  single-cycle strobe; sample `serial_in` this cycle.
- `serial_in`  in  1  serial data bit.
- `data_read`  in  1  consumer acknowledges the held word.
- `rcv_data`  out  DATA_BITS  last completed word, held until the next completion.
- `data_ready`  out  1  one-cycle pulse when `rcv_data` is updated.
- `data_valid`  out  1  held word is unread.
- `overrun_error`  out  1  sticky; a word completed while `data_valid` was 1.
- `busy`  out  1  frame in progress (state is not IDLE).
- `parity_error`  out  1  only when `RX_PARITY_EN` is defined; indicates parity mismatch on the last word.

## Operation
- States: IDLE, SHIFT, PARITY (macro only), DONE.
- Reset values: all outputs are 0, state is IDLE, the shift register and counter are 0.
- IDLE + `frame_start` → SHIFT; the shift register and counter are cleared. A `shift_enable` in the same cycle is ignored.
- SHIFT + `shift_enable`: sample `serial_in`.
  - When `MSB_FIRST`=0, the bit enters at the MSB and the register shifts right.
  - When `MSB_FIRST`=1, the bit enters at bit 0 and the register shifts left.
  - The counter increments on each sample.
- On the sample that makes count = `DATA_BITS`, go to PARITY if the macro is defined, otherwise go to DONE.
- PARITY + `shift_enable`: sample the parity bit and compute the mismatch against the XOR of the word (inverted when `PARITY_ODD`) → DONE.
- DONE (exactly one cycle) → IDLE. At the edge ending DONE:
  - `rcv_data` is loaded from the shift register.
  - `data_ready` is 1 for one cycle.
  - `data_valid` is set to 1.
  - `parity_error` is updated.
- Overrun: if `data_valid`=1 and `data_read`=0 at the DONE edge, `overrun_error` is set and `rcv_data` is still overwritten with the new word.
- `data_read` clears both `data_valid` and `overrun_error`.
- `data_read` in the same cycle as DONE: the new word loads, `data_valid` stays 1, and `overrun_error` is not set.
- `frame_start` in SHIFT or PARITY restarts the frame: counter cleared, partial word discarded, and any `shift_enable` that cycle is ignored. `frame_start` in DONE is ignored.
- `shift_enable` in IDLE or DONE has no effect.
- `rst` mid-frame aborts immediately; the partial word is lost and all outputs return to 0.
- Counter width is $clog2(DATA_BITS+1). The counter never wraps, because it is cleared on entry to SHIFT.

## Timing
- The final-bit sample edge (E0) moves the state to DONE.
- The next edge (E1) updates `rcv_data` and raises `data_ready`. Latency is one clock from the final sample edge.
- `busy` rises at the edge after `frame_start` and falls at E1.
- Back-to-back frames are allowed. The minimum gap is one cycle in DONE before the next `frame_start` is accepted.
- `shift_enable` strobes may arrive in consecutive cycles; each one is sampled.

## Configuration
- `RX_PARITY_EN`
  - Defined: adds the PARITY state, the `parity_error` port and the `PARITY_ODD` checking. A frame is `DATA_BITS`+1 samples.
  - Undefined: no PARITY state and no `parity_error` port. A frame is `DATA_BITS` samples.

## Structure
- Package `rx_pkg` holds:
  - the state enum typedef `rx_state_t`;
  - the `RX_MIN_BITS`/`RX_MAX_BITS` constants (5/16);
  - a parity helper function.
- Sub-module `rx_bit_counter` is parametrised by its terminal count and has clear/enable inputs and a terminal-count output.
- The top level holds the FSM, the shift register and the holding/status registers.

## Test plan
- LSB-first word (`DATA_BITS`=8, `MSB_FIRST`=0): `frame_start`, then bits 1,0,1,0,0,1,0,1 → `rcv_data`=0xA5, one `data_ready` pulse one clock after the last sample, `data_valid`=1.
- MSB-first word (`DATA_BITS`=5, `MSB_FIRST`=1): bits 1,0,0,1,1 → `rcv_data`=5'h13.
- Overrun: two 0xA5/0x3C frames with no `data_read` → `rcv_data`=0x3C, `overrun_error`=1. Then `data_read` → `overrun_error`=0 and `data_valid`=0.
- Restart and reset: `frame_start` after 3 bits, then a full 0x5A frame → `rcv_data`=0x5A. Asserting `rst` after 4 bits → all outputs 0 and `busy`=0.
- With `RX_PARITY_EN`, even parity: 0xA5 with parity 0 → `parity_error`=0. The same word with parity 1 → `parity_error`=1 and the word is still delivered.
- Collision: `data_read` in the DONE cycle while `data_valid`=1 → `overrun_error` stays 0 and the new word is held.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared types and helpers for the receive deserialiser.
// The parity helper is used only when the block is built with RX_PARITY_EN.
package rx_pkg;

    localparam int RX_MIN_BITS = 5;
    localparam int RX_MAX_BITS = 16;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_SHIFT  = 2'd1,
        RX_PARITY = 2'd2,
        RX_DONE   = 2'd3
    } rx_state_t;

    // Expected parity bit for a zero-extended word; odd sense inverts the XOR.
    function automatic logic rx_parity(input logic [RX_MAX_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Sample counter for one frame: clearable, saturating at TERMINAL.
// tc_o flags that the next enabled sample is the one that reaches TERMINAL.
module rx_bit_counter
    import rx_pkg::*;
#(
    parameter int TERMINAL = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = $clog2(TERMINAL + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over enable; never steps past TERMINAL.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != CW'(TERMINAL))) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Looks only at the registered count so the FSM can use it without a loop.
    assign tc_o = (count_q == CW'(TERMINAL - 1));

endmodule

// File: rtl/rx_deser.sv
// Serial-to-parallel receive deserialiser with holding register and status flags.
// Define RX_PARITY_EN to add a trailing parity sample and the parity_error output.
module rx_deser
    import rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int MSB_FIRST  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_start,
    input  logic                 shift_enable,
    input  logic                 serial_in,
    input  logic                 data_read,
    output logic [DATA_BITS-1:0] rcv_data,
    output logic                 data_ready,
    output logic                 data_valid,
    output logic                 overrun_error,
    output logic                 busy
`ifdef RX_PARITY_EN
   ,output logic                 parity_error
`endif
);

    localparam bit CFG_OK = (DATA_BITS >= RX_MIN_BITS) && (DATA_BITS <= RX_MAX_BITS) &&
                            (MSB_FIRST == 0 || MSB_FIRST == 1) &&
                            (PARITY_ODD == 0 || PARITY_ODD == 1);

    if (!CFG_OK) begin : g_bad_cfg
        $error("rx_deser: illegal DATA_BITS/MSB_FIRST/PARITY_ODD combination");
    end

    rx_state_t            state_q, state_d;
    logic [DATA_BITS-1:0] sreg_q, sreg_d;
    logic [DATA_BITS-1:0] rcv_data_q, rcv_data_d;
    logic                 data_ready_q, data_ready_d;
    logic                 data_valid_q, data_valid_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;
    logic [DATA_BITS-1:0] shifted_s;
    logic                 cnt_clr_s;
    logic                 cnt_en_s;
    logic                 cnt_tc_s;
`ifdef RX_PARITY_EN
    logic                 par_pend_q, par_pend_d;
    logic                 parity_error_q, parity_error_d;
`endif

    rx_bit_counter #(
        .TERMINAL (DATA_BITS)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (cnt_clr_s),
        .en_i  (cnt_en_s),
        .tc_o  (cnt_tc_s)
    );

    assign shifted_s = (MSB_FIRST != 0) ? {sreg_q[DATA_BITS-2:0], serial_in}
                                        : {serial_in, sreg_q[DATA_BITS-1:1]};

    // Frame FSM, shift register and holding/status next-state logic.
    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        rcv_data_d   = rcv_data_q;
        data_ready_d = 1'b0;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;
        cnt_clr_s    = 1'b0;
        cnt_en_s     = 1'b0;
`ifdef RX_PARITY_EN
        par_pend_d     = par_pend_q;
        parity_error_d = parity_error_q;
`endif
        if (data_read) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            data_valid_d = data_valid_q;
        end

        case (state_q)
            RX_IDLE: begin
                if (frame_start) begin
                    state_d   = RX_SHIFT;
                    sreg_d    = '0;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d = RX_IDLE;
                end
            end
            RX_SHIFT: begin
                if (frame_start) begin
                    sreg_d    = '0;
                    cnt_clr_s = 1'b1;
                end else if (shift_enable) begin
                    sreg_d   = shifted_s;
                    cnt_en_s = 1'b1;
                    if (cnt_tc_s) begin
`ifdef RX_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_DONE;
`endif
                    end else begin
                        state_d = RX_SHIFT;
                    end
                end else begin
                    state_d = RX_SHIFT;
                end
            end
`ifdef RX_PARITY_EN
            RX_PARITY: begin
                if (frame_start) begin
                    state_d   = RX_SHIFT;
                    sreg_d    = '0;
                    cnt_clr_s = 1'b1;
                end else if (shift_enable) begin
                    par_pend_d = serial_in ^ rx_parity(RX_MAX_BITS'(sreg_q), (PARITY_ODD != 0));
                    state_d    = RX_DONE;
                end else begin
                    state_d = RX_PARITY;
                end
            end
`endif
            RX_DONE: begin
                // A read in this cycle only suppresses the overrun; the new word is still unread.
                state_d      = RX_IDLE;
                rcv_data_d   = sreg_q;
                data_ready_d = 1'b1;
                data_valid_d = 1'b1;
                if (data_valid_q && !data_read) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = 1'b0 | (overrun_q & ~data_read);
                end
`ifdef RX_PARITY_EN
                parity_error_d = par_pend_q;
`endif
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        busy_d = (state_d != RX_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= RX_IDLE;
            sreg_q       <= '0;
            rcv_data_q   <= '0;
            data_ready_q <= 1'b0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            rcv_data_q   <= rcv_data_d;
            data_ready_q <= data_ready_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
        end
    end

`ifdef RX_PARITY_EN
    // Parity capture and reported parity status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_pend_q     <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            par_pend_q     <= par_pend_d;
            parity_error_q <= parity_error_d;
        end
    end

    assign parity_error = parity_error_q;
`endif

    assign rcv_data      = rcv_data_q;
    assign data_ready    = data_ready_q;
    assign data_valid    = data_valid_q;
    assign overrun_error = overrun_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_rx_deser.sv
// Directed bench for rx_deser: an 8-bit LSB-first and a 5-bit MSB-first instance
// share the stimulus; each test task checks its own expected values.
module tb_rx_deser;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       shift_enable;
    logic       serial_in;
    logic       data_read;
    logic [7:0] rcv8;
    logic       rdy8, val8, ovr8, busy8;
    logic [4:0] rcv5;
    logic       rdy5, val5, ovr5, busy5;
`ifdef RX_PARITY_EN
    logic       perr8, perr5;
`endif

    int vecs = 0;
    int errs = 0;

    rx_deser #(.DATA_BITS(8), .MSB_FIRST(0), .PARITY_ODD(0)) dut8 (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .shift_enable  (shift_enable),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rcv_data      (rcv8),
        .data_ready    (rdy8),
        .data_valid    (val8),
        .overrun_error (ovr8),
        .busy          (busy8)
`ifdef RX_PARITY_EN
       ,.parity_error  (perr8)
`endif
    );

    rx_deser #(.DATA_BITS(5), .MSB_FIRST(1), .PARITY_ODD(0)) dut5 (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .shift_enable  (shift_enable),
        .serial_in     (serial_in),
        .data_read     (data_read),
        .rcv_data      (rcv5),
        .data_ready    (rdy5),
        .data_valid    (val5),
        .overrun_error (ovr5),
        .busy          (busy5)
`ifdef RX_PARITY_EN
       ,.parity_error  (perr5)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        shift_enable = 1'b0;
        serial_in = 1'b0;
        data_read = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // Drives one frame up to and including the last sample edge; the DUT is then in DONE.
    // The frame_start cycle also carries a strobe that must be ignored.
    task automatic send_bits(input logic [15:0] w, input int n, input bit msb, input bit par, input int gap);
        logic b;
        frame_start = 1'b1;
        shift_enable = 1'b1;
        serial_in = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            b = msb ? w[n-1-i] : w[i];
            serial_in = b;
            shift_enable = 1'b1;
            tick();
            shift_enable = 1'b0;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    serial_in = ~b;
                    tick();
                end
            end
        end
`ifdef RX_PARITY_EN
        serial_in = par;
        shift_enable = 1'b1;
        tick();
        shift_enable = 1'b0;
`else
        serial_in = par;
`endif
        serial_in = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_start = 1'b0;
        shift_enable = 1'b0;
        serial_in = 1'b0;
        data_read = 1'b0;
        tick();
        vecs++;
        if ({rcv8, rdy8, val8, ovr8, busy8} !== 12'h000) begin
            errs++;
            $display("FAIL reset8: got %h want 000", {rcv8, rdy8, val8, ovr8, busy8});
        end
        vecs++;
        if ({rcv5, rdy5, val5, ovr5, busy5} !== 9'h000) begin
            errs++;
            $display("FAIL reset5: got %h want 000", {rcv5, rdy5, val5, ovr5, busy5});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lsb_word();
        do_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        vecs++;
        if (busy8 !== 1'b1) begin errs++; $display("FAIL lsb_busy_rise: got %b want 1", busy8); end
        do_reset();
        send_bits(16'h00A5, 8, 1'b0, 1'b0, 0);
        vecs++;
        if ({rdy8, busy8} !== 2'b01) begin errs++; $display("FAIL lsb_done_cycle: rdy/busy got %b want 01", {rdy8, busy8}); end
        tick();
        vecs++;
        if (rcv8 !== 8'hA5) begin errs++; $display("FAIL lsb_data: got %h want a5", rcv8); end
        vecs++;
        if ({rdy8, val8, ovr8, busy8} !== 4'b1100) begin errs++; $display("FAIL lsb_flags: got %b want 1100", {rdy8, val8, ovr8, busy8}); end
        tick();
        vecs++;
        if ({rdy8, val8} !== 2'b01) begin errs++; $display("FAIL lsb_pulse_end: got %b want 01", {rdy8, val8}); end
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        vecs++;
        if (val8 !== 1'b0) begin errs++; $display("FAIL lsb_read_clear: got %b want 0", val8); end
    endtask

    task automatic test_msb_word();
        do_reset();
        send_bits(16'h0013, 5, 1'b1, 1'b1, 0);
        vecs++;
        if (rdy5 !== 1'b0) begin errs++; $display("FAIL msb_done_cycle: got %b want 0", rdy5); end
        tick();
        vecs++;
        if (rcv5 !== 5'h13) begin errs++; $display("FAIL msb_data: got %h want 13", rcv5); end
        vecs++;
        if ({rdy5, val5} !== 2'b11) begin errs++; $display("FAIL msb_flags: got %b want 11", {rdy5, val5}); end
    endtask

    task automatic test_overrun();
        do_reset();
        send_bits(16'h00A5, 8, 1'b0, 1'b0, 0);
        tick();
        send_bits(16'h003C, 8, 1'b0, 1'b0, 0);
        vecs++;
        if (ovr8 !== 1'b0) begin errs++; $display("FAIL ovr_early: got %b want 0", ovr8); end
        tick();
        vecs++;
        if (rcv8 !== 8'h3C) begin errs++; $display("FAIL ovr_data: got %h want 3c", rcv8); end
        vecs++;
        if ({ovr8, val8} !== 2'b11) begin errs++; $display("FAIL ovr_set: got %b want 11", {ovr8, val8}); end
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        vecs++;
        if ({ovr8, val8} !== 2'b00) begin errs++; $display("FAIL ovr_clear: got %b want 00", {ovr8, val8}); end
    endtask

    task automatic test_restart_and_reset();
        do_reset();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serial_in = 1'b1;
            shift_enable = 1'b1;
            tick();
        end
        shift_enable = 1'b0;
        send_bits(16'h005A, 8, 1'b0, 1'b0, 0);
        vecs++;
        if ({rdy8, busy8} !== 2'b01) begin errs++; $display("FAIL restart_done_cycle: got %b want 01", {rdy8, busy8}); end
        tick();
        vecs++;
        if (rcv8 !== 8'h5A) begin errs++; $display("FAIL restart_data: got %h want 5a", rcv8); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serial_in = 1'b1;
            shift_enable = 1'b1;
            tick();
        end
        shift_enable = 1'b0;
        vecs++;
        if ({busy8, val8} !== 2'b11) begin errs++; $display("FAIL midframe_state: got %b want 11", {busy8, val8}); end
        rst = 1'b1;
        #1;
        vecs++;
        if ({rcv8, rdy8, val8, ovr8, busy8} !== 12'h000) begin
            errs++;
            $display("FAIL midframe_reset: got %h want 000", {rcv8, rdy8, val8, ovr8, busy8});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        do_reset();
        send_bits(16'h00A5, 8, 1'b0, 1'b0, 0);
        tick();
        send_bits(16'h003C, 8, 1'b0, 1'b0, 0);
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        vecs++;
        if (rcv8 !== 8'h3C) begin errs++; $display("FAIL collide_data: got %h want 3c", rcv8); end
        vecs++;
        if ({val8, ovr8} !== 2'b10) begin errs++; $display("FAIL collide_flags: got %b want 10", {val8, ovr8}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_bits(16'h00A5, 8, 1'b0, 1'b0, 0);
        frame_start = 1'b1;
        shift_enable = 1'b1;
        tick();
        frame_start = 1'b0;
        shift_enable = 1'b0;
        vecs++;
        if ({busy8, rcv8} !== 9'h0A5) begin errs++; $display("FAIL done_start_ignored: got %h want 0a5", {busy8, rcv8}); end
        send_bits(16'h003C, 8, 1'b0, 1'b0, 0);
        tick();
        vecs++;
        if ({rdy8, rcv8} !== 9'h13C) begin errs++; $display("FAIL b2b_second: got %h want 13c", {rdy8, rcv8}); end
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        send_bits(16'h0096, 8, 1'b0, 1'b0, 2);
        tick();
        vecs++;
        if ({rdy8, rcv8} !== 9'h196) begin errs++; $display("FAIL gapped_strobes: got %h want 196", {rdy8, rcv8}); end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        do_reset();
        send_bits(16'h00A5, 8, 1'b0, 1'b0, 0);
        tick();
        vecs++;
        if ({perr8, rcv8} !== 9'h0A5) begin errs++; $display("FAIL parity_good: got %h want 0a5", {perr8, rcv8}); end
        send_bits(16'h00A5, 8, 1'b0, 1'b1, 0);
        tick();
        vecs++;
        if ({perr8, rdy8, rcv8} !== 10'h3A5) begin errs++; $display("FAIL parity_bad: got %h want 3a5", {perr8, rdy8, rcv8}); end
    endtask
`endif

    initial begin
        test_reset();
        test_lsb_word();
        test_msb_word();
        test_overrun();
        test_restart_and_reset();
        test_collision();
        test_back_to_back();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
